circular_convolution_seq: RTL and testbench
===========================================

Name: circular_convolution_seq

Overview:
Sequential, parametrised successor to the combinational circular convolution block. It loads two signed length-N sequences over a valid/ready stream and computes either the N-point circular or the (2N-1)-point linear convolution, selected at start. It uses one shared MAC, one product per cycle, so the block scales to large N without an N² multiplier array. Results leave on a valid/ready output stream with a last marker, for use between sample buffers and downstream filtering.

Parameters:
N, 8, sequence length of A and B (N >= 2)
WIDTH, 8, signed sample width
ACC_W, 2*WIDTH+$clog2(N)+1, signed accumulator/output width (derived; never overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  1  0 = circular (N outputs), 1 = linear (2N-1 outputs); latched on accepted start
in_valid  in  1  input sample pair valid
in_ready  out  1  block accepts a pair (high only in LOAD)
in_a  in  WIDTH  signed sample A[i]; i = arrival order 0..N-1
in_b  in  WIDTH  signed sample B[i]; same index as in_a
out_valid  out  1  out_data holds result C[k]
out_ready  in  1  downstream accepts C[k]
out_data  out  ACC_W  signed C[k], k in ascending order
out_last  out  1  high with the final C[k]
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last output handshake

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; sample memories, indices and accumulator cleared. A reset in any state aborts the operation immediately. No partial output follows release.
- States: IDLE -> LOAD -> MAC -> OUT -> (MAC | IDLE).
- IDLE: start=1 latches mode and moves to LOAD next cycle. start in any other state is ignored.
- LOAD: in_ready=1. Each in_valid&in_ready cycle writes A[i]/B[i] and increments i. The N-th handshake moves to MAC with k=0, j=0, acc=0. in_ready drops in the cycle after the N-th handshake.
- MAC: exactly N cycles per output, j=0..N-1, acc += A[j]*B[idx].
  - Circular: idx = (k-j) mod N, with wrap handled by compare/add-N, not division.
  - Linear: the term is zero when k-j<0 or k-j>N-1; the cycle is still spent, so timing is mode-independent.
  - Products are full 2*WIDTH signed; the accumulator is sign-extended to ACC_W. The result cannot overflow by construction.
- OUT: out_valid=1 with out_data=acc.
  - out_last=1 when k = K-1, where K = N (circular) or 2N-1 (linear).
  - out_data, out_last and out_valid stay stable until out_ready. Backpressure of any length is legal.
  - On handshake: if not last, k++, clear acc, go to MAC. If last, go to IDLE with done=1 in the first IDLE cycle.
- Latency: the first out_valid comes N cycles after the load-complete handshake. Minimum operation length is K*(N+1) cycles after load.
- start asserted in the done cycle is accepted (state is IDLE).
- Input samples persist until the next LOAD overwrites them. Mode changes take effect only on a new start.

Decomposition:
- Package conv_pkg holds:
  - state_t enum {IDLE, LOAD, MAC, OUT}
  - mode_t enum {MODE_CIRC, MODE_LIN}
  - helper function acc_width(N, WIDTH)
- One sub-module, conv_mac: signed WIDTH x WIDTH multiply with clear/enable accumulator of width ACC_W. The top module holds the FSM, index counters and sample memories.

Test Plan:
- N=4, circular, A=B={1,1,1,1} -> C={4,4,4,4}; out_last on 4th; done one cycle later; first out_valid 4 cycles after last load handshake.
- N=4, linear, A=B={1,1,1,1} -> C={1,2,3,4,3,2,1}, out_last on 7th.
- N=4, circular, A={1,2,3,4}, B={0,1,0,0} -> C={4,1,2,3}, which checks wrap. Linear with the same inputs -> {0,1,2,3,4,0,0}.
- N=4, circular, all samples -128 -> every C = 65536 (fits ACC_W=19). Also A={-1,2,-3,4}, B={1,0,0,0} -> {-1,2,-3,4}.
- Backpressure and stalls:
  - Hold out_ready=0 for 5 cycles on C[1]; out_data/out_last must stay stable and no output may be lost or duplicated.
  - Toggle in_valid randomly during LOAD; the same result is required.
- Assert reset=0 mid-MAC of C[2]: all outputs are 0 asynchronously and the state is IDLE. A start during busy is ignored. After release, a fresh start gives correct results.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and width helper for the sequential convolution block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MAC,
    OUT
  } state_t;

  typedef enum logic {
    MODE_CIRC,
    MODE_LIN
  } mode_t;

  // Worst-case sum of N full-width products plus sign headroom.
  function automatic int acc_width(input int n, input int width);
    return 2 * width + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/circular_convolution_seq_if.sv
// Control, sample-input and result-output streams of the convolution block.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on samples, out_valid/out_ready on results.
// master: producer/consumer side (drives start, mode, in_*, out_ready).
// slave : the convolution block (drives in_ready, out_*, busy, done).
interface circular_convolution_seq_if
  import conv_pkg::*;
#(
  parameter int N     = 8,
  parameter int WIDTH = 8,
  parameter int ACC_W = acc_width(N, WIDTH)
);

  logic                    start;
  logic                    mode;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_a;
  logic signed [WIDTH-1:0] in_b;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_last;
  logic                    busy;
  logic                    done;

  modport master (
    output start, mode, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    input  start, mode, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, done
  );

endinterface

// File: rtl/conv_mac.sv
// Signed WIDTH x WIDTH multiply feeding a clearable ACC_W accumulator.
// Latency: one cycle from en to updated acc.
// Backpressure: none; the caller gates en.
// Ports: clk, reset (async active-low), clr (sync clear, wins over en),
//        en (accumulate a*b), a/b (signed operands), acc (registered sum).
module conv_mac #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 19
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;

  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/circular_convolution_seq.sv
// Sequential N-point circular / (2N-1)-point linear convolution on one shared MAC.
// Latency: first result N cycles after the last load handshake; N+1 cycles per result.
// Backpressure: in_ready only in LOAD; a result is held stable while out_ready is low.
// Ports: clk, reset (async active-low), io (slave side of circular_convolution_seq_if).
module circular_convolution_seq
  import conv_pkg::*;
#(
  parameter int N     = 8,
  parameter int WIDTH = 8,
  parameter int ACC_W = acc_width(N, WIDTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  circular_convolution_seq_if.slave   io
);

  localparam int I_W = $clog2(N);
  localparam int K_W = $clog2(2 * N);
  localparam int D_W = K_W + 2;

  localparam logic [I_W-1:0]        I_LAST      = I_W'(N - 1);
  localparam logic [K_W-1:0]        K_LAST_CIRC = K_W'(N - 1);
  localparam logic [K_W-1:0]        K_LAST_LIN  = K_W'(2 * N - 2);
  localparam logic signed [D_W-1:0] N_S         = D_W'(N);
  localparam logic signed [D_W-1:0] N_M1_S      = D_W'(N - 1);

  state_t                  state_q, state_d;
  mode_t                   mode_q, mode_d;
  logic [I_W-1:0]          i_q, i_d;
  logic [I_W-1:0]          j_q, j_d;
  logic [K_W-1:0]          k_q, k_d;
  logic                    done_q, done_d;
  logic signed [WIDTH-1:0] mem_a_q [N];
  logic signed [WIDTH-1:0] mem_a_d [N];
  logic signed [WIDTH-1:0] mem_b_q [N];
  logic signed [WIDTH-1:0] mem_b_d [N];

  logic signed [D_W-1:0]   diff;
  logic signed [D_W-1:0]   idx_full;
  logic [I_W-1:0]          idx;
  logic                    term_vld;
  logic                    k_last;
  logic                    mac_clr;
  logic                    mac_en;
  logic signed [WIDTH-1:0] mac_b;
  logic signed [ACC_W-1:0] acc;

  // B index for the current term: k-j, wrapped by +N in circular mode,
  // or flagged as a zero term in linear mode when it falls outside 0..N-1.
  always_comb begin
    diff     = D_W'(k_q) - D_W'(j_q);
    idx_full = diff;
    term_vld = 1'b1;
    if (mode_q == MODE_CIRC) begin
      if (diff[D_W-1]) begin
        idx_full = diff + N_S;
      end
    end else begin
      term_vld = !diff[D_W-1] && (diff <= N_M1_S);
    end
    idx    = idx_full[I_W-1:0];
    mac_b  = term_vld ? mem_b_q[idx] : '0;
    k_last = (mode_q == MODE_LIN) ? (k_q == K_LAST_LIN) : (k_q == K_LAST_CIRC);
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    done_d  = 1'b0;
    mem_a_d = mem_a_q;
    mem_b_d = mem_b_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.start) begin
          mode_d  = mode_t'(io.mode);
          i_d     = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (io.in_valid) begin
          mem_a_d[i_q] = io.in_a;
          mem_b_d[i_q] = io.in_b;
          if (i_q == I_LAST) begin
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            mac_clr = 1'b1;
            state_d = MAC;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      MAC: begin
        // Zero terms still take their cycle so timing is mode-independent.
        mac_en = 1'b1;
        if (j_q == I_LAST) begin
          j_d     = '0;
          state_d = OUT;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      OUT: begin
        if (io.out_ready) begin
          if (k_last) begin
            k_d     = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            k_d     = k_q + 1'b1;
            mac_clr = 1'b1;
            state_d = MAC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_CIRC;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      for (int n = 0; n < N; n++) begin
        mem_a_q[n] <= '0;
        mem_b_q[n] <= '0;
      end
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      mem_a_q <= mem_a_d;
      mem_b_q <= mem_b_d;
    end
  end

  conv_mac #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (mem_a_q[j_q]),
    .b     (mac_b),
    .acc   (acc)
  );

  // All outputs decode from reset flops, so an async reset zeroes them at once.
  assign io.in_ready  = (state_q == LOAD);
  assign io.out_valid = (state_q == OUT);
  assign io.out_data  = (state_q == OUT) ? acc : '0;
  assign io.out_last  = (state_q == OUT) && k_last;
  assign io.busy      = (state_q != IDLE);
  assign io.done      = done_q;

endmodule

// File: tb/tb_circular_convolution_seq.sv
module tb_circular_convolution_seq;

  typedef logic signed [7:0]  smp_arr_t [4];
  typedef logic signed [18:0] res_arr_t [7];

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  circular_convolution_seq_if #(.N(4), .WIDTH(8)) io ();

  circular_convolution_seq #(.N(4), .WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one complete operation and records what came out; no checking here.
  task automatic do_op(input bit m, input smp_arr_t a, input smp_arr_t b,
                       input int stall_k, input int stall_n, input bit rand_load,
                       output res_arr_t got, output bit [6:0] lst, output int n_got,
                       output int lat, output bit done_seen, output bit stable_ok);
    int idx, cyc, stall_left;
    bit hs;
    logic signed [18:0] ref_d;
    logic ref_l;
    got = '{default: 0};
    lst = '0; n_got = 0; lat = 0; done_seen = 1'b0; stable_ok = 1'b1;
    stall_left = stall_n; ref_d = '0; ref_l = 1'b0;
    io.start = 1'b1; io.mode = m;
    @(posedge clk); #1;
    io.start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 4 && cyc < 200) begin
      io.in_valid = rand_load ? 1'($urandom_range(0, 1)) : 1'b1;
      io.in_a = a[idx];
      io.in_b = b[idx];
      hs = io.in_valid && io.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) idx++;
    end
    io.in_valid = 1'b0;
    while (!io.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    cyc = 0;
    while (n_got < 7 && cyc < 400) begin
      hs = 1'b0;
      if (io.out_valid && n_got == stall_k && stall_left > 0) begin
        if (stall_left == stall_n) begin
          ref_d = io.out_data; ref_l = io.out_last;
        end else if (io.out_data !== ref_d || io.out_last !== ref_l) begin
          stable_ok = 1'b0;
        end
        io.out_ready = 1'b0;
        stall_left--;
      end else begin
        io.out_ready = 1'b1;
        hs = io.out_valid;
        if (hs && stall_n > 0 && n_got == stall_k &&
            (io.out_data !== ref_d || io.out_last !== ref_l)) stable_ok = 1'b0;
      end
      if (hs) begin
        got[n_got] = io.out_data;
        lst[n_got] = io.out_last;
        n_got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (hs && lst[n_got-1]) begin
        done_seen = io.done;
        break;
      end
    end
    io.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    io.start = 0; io.mode = 0; io.in_valid = 0; io.in_a = 0; io.in_b = 0; io.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (io.in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready got %b want 0", io.in_ready); end
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", io.out_valid); end
    checks++; if (io.out_data !== 19'sd0) begin errors++; $display("FAIL reset out_data got %0d want 0", io.out_data); end
    checks++; if (io.busy !== 1'b0 || io.done !== 1'b0 || io.out_last !== 1'b0) begin
      errors++; $display("FAIL reset busy/done/last got %b%b%b want 000", io.busy, io.done, io.out_last);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_circular();
    smp_arr_t va [4];
    smp_arr_t vb [4];
    res_arr_t ve [4];
    res_arr_t got;
    bit [6:0] lst;
    int n_got, lat;
    bit dn, st;
    va[0] = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};      vb[0] = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
    ve[0] = '{19'sd4, 19'sd4, 19'sd4, 19'sd4, 19'sd0, 19'sd0, 19'sd0};
    va[1] = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};      vb[1] = '{8'sd0, 8'sd1, 8'sd0, 8'sd0};
    ve[1] = '{19'sd4, 19'sd1, 19'sd2, 19'sd3, 19'sd0, 19'sd0, 19'sd0};
    va[2] = '{8'sh80, 8'sh80, 8'sh80, 8'sh80};  vb[2] = '{8'sh80, 8'sh80, 8'sh80, 8'sh80};
    ve[2] = '{19'sd65536, 19'sd65536, 19'sd65536, 19'sd65536, 19'sd0, 19'sd0, 19'sd0};
    va[3] = '{-8'sd1, 8'sd2, -8'sd3, 8'sd4};    vb[3] = '{8'sd1, 8'sd0, 8'sd0, 8'sd0};
    ve[3] = '{-19'sd1, 19'sd2, -19'sd3, 19'sd4, 19'sd0, 19'sd0, 19'sd0};
    for (int v = 0; v < 4; v++) begin
      do_op(1'b0, va[v], vb[v], -1, 0, 1'b0, got, lst, n_got, lat, dn, st);
      checks++; if (n_got !== 4) begin errors++; $display("FAIL circ%0d count got %0d want 4", v, n_got); end
      for (int k = 0; k < 4; k++) begin
        checks++; if (got[k] !== ve[v][k]) begin errors++; $display("FAIL circ%0d C[%0d] got %0d want %0d", v, k, got[k], ve[v][k]); end
        checks++; if (lst[k] !== (k == 3)) begin errors++; $display("FAIL circ%0d last[%0d] got %b want %b", v, k, lst[k], k == 3); end
      end
      checks++; if (lat !== 4) begin errors++; $display("FAIL circ%0d latency got %0d want 4", v, lat); end
      checks++; if (dn !== 1'b1) begin errors++; $display("FAIL circ%0d done got %b want 1", v, dn); end
    end
  endtask

  task automatic test_linear();
    smp_arr_t va [2];
    smp_arr_t vb [2];
    res_arr_t ve [2];
    res_arr_t got;
    bit [6:0] lst;
    int n_got, lat;
    bit dn, st;
    va[0] = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};  vb[0] = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
    ve[0] = '{19'sd1, 19'sd2, 19'sd3, 19'sd4, 19'sd3, 19'sd2, 19'sd1};
    va[1] = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};  vb[1] = '{8'sd0, 8'sd1, 8'sd0, 8'sd0};
    ve[1] = '{19'sd0, 19'sd1, 19'sd2, 19'sd3, 19'sd4, 19'sd0, 19'sd0};
    for (int v = 0; v < 2; v++) begin
      do_op(1'b1, va[v], vb[v], -1, 0, 1'b0, got, lst, n_got, lat, dn, st);
      checks++; if (n_got !== 7) begin errors++; $display("FAIL lin%0d count got %0d want 7", v, n_got); end
      for (int k = 0; k < 7; k++) begin
        checks++; if (got[k] !== ve[v][k]) begin errors++; $display("FAIL lin%0d C[%0d] got %0d want %0d", v, k, got[k], ve[v][k]); end
        checks++; if (lst[k] !== (k == 6)) begin errors++; $display("FAIL lin%0d last[%0d] got %b want %b", v, k, lst[k], k == 6); end
      end
      checks++; if (lat !== 4) begin errors++; $display("FAIL lin%0d latency got %0d want 4", v, lat); end
      checks++; if (dn !== 1'b1) begin errors++; $display("FAIL lin%0d done got %b want 1", v, dn); end
    end
  endtask

  task automatic test_backpressure();
    smp_arr_t a, b;
    res_arr_t got;
    res_arr_t e;
    bit [6:0] lst;
    int n_got, lat;
    bit dn, st;
    a = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    b = '{8'sd0, 8'sd1, 8'sd0, 8'sd0};
    e = '{19'sd4, 19'sd1, 19'sd2, 19'sd3, 19'sd0, 19'sd0, 19'sd0};
    do_op(1'b0, a, b, 1, 5, 1'b0, got, lst, n_got, lat, dn, st);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL bp stable got %b want 1", st); end
    checks++; if (n_got !== 4) begin errors++; $display("FAIL bp count got %0d want 4", n_got); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (got[k] !== e[k]) begin errors++; $display("FAIL bp C[%0d] got %0d want %0d", k, got[k], e[k]); end
    end
    checks++; if (lst !== 7'b0001000) begin errors++; $display("FAIL bp last got %b want 0001000", lst); end
  endtask

  task automatic test_random_load();
    smp_arr_t a, b;
    res_arr_t got;
    res_arr_t e;
    bit [6:0] lst;
    int n_got, lat;
    bit dn, st;
    a = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    b = '{8'sd0, 8'sd1, 8'sd0, 8'sd0};
    e = '{19'sd0, 19'sd1, 19'sd2, 19'sd3, 19'sd4, 19'sd0, 19'sd0};
    for (int r = 0; r < 2; r++) begin
      do_op(1'b1, a, b, -1, 0, 1'b1, got, lst, n_got, lat, dn, st);
      checks++; if (n_got !== 7) begin errors++; $display("FAIL rand%0d count got %0d want 7", r, n_got); end
      for (int k = 0; k < 7; k++) begin
        checks++; if (got[k] !== e[k]) begin errors++; $display("FAIL rand%0d C[%0d] got %0d want %0d", r, k, got[k], e[k]); end
      end
      checks++; if (lat !== 4) begin errors++; $display("FAIL rand%0d latency got %0d want 4", r, lat); end
    end
  endtask

  task automatic test_reset_abort();
    logic signed [18:0] g [2];
    int n, cyc, seen;
    bit hs;
    smp_arr_t a, b;
    res_arr_t got;
    res_arr_t e;
    bit [6:0] lst;
    int n_got, lat;
    bit dn, st;
    g[0] = '0; g[1] = '0;
    io.start = 1'b1; io.mode = 1'b0;
    @(posedge clk); #1;
    io.start = 1'b0;
    n = 0; cyc = 0;
    io.in_a = 8'sd1; io.in_b = 8'sd1;
    while (n < 4 && cyc < 100) begin
      io.in_valid = 1'b1;
      hs = io.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) n++;
    end
    io.in_valid = 1'b0;
    // start (with the other mode) while busy must not restart or re-latch mode
    io.start = 1'b1; io.mode = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    io.start = 1'b0;
    n = 0; cyc = 0; io.out_ready = 1'b1;
    while (n < 2 && cyc < 100) begin
      hs = io.out_valid;
      if (hs) g[n] = io.out_data;
      @(posedge clk); #1;
      cyc++;
      if (hs) n++;
    end
    io.out_ready = 1'b0;
    checks++; if (n !== 2) begin errors++; $display("FAIL abort count got %0d want 2", n); end
    checks++; if (g[0] !== 19'sd4 || g[1] !== 19'sd4) begin
      errors++; $display("FAIL abort pre-reset C0/C1 got %0d/%0d want 4/4", g[0], g[1]);
    end
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    checks++; if (io.busy !== 1'b0 || io.in_ready !== 1'b0 || io.out_valid !== 1'b0) begin
      errors++; $display("FAIL abort busy/in_ready/out_valid got %b%b%b want 000", io.busy, io.in_ready, io.out_valid);
    end
    checks++; if (io.out_data !== 19'sd0 || io.out_last !== 1'b0 || io.done !== 1'b0) begin
      errors++; $display("FAIL abort data/last/done got %0d/%b/%b want 0/0/0", io.out_data, io.out_last, io.done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    seen = 0; io.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (io.out_valid || io.busy) seen++;
      @(posedge clk); #1;
    end
    io.out_ready = 1'b0;
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort post-release activity got %0d cycles want 0", seen); end
    a = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    b = '{8'sd0, 8'sd1, 8'sd0, 8'sd0};
    e = '{19'sd0, 19'sd1, 19'sd2, 19'sd3, 19'sd4, 19'sd0, 19'sd0};
    do_op(1'b1, a, b, -1, 0, 1'b0, got, lst, n_got, lat, dn, st);
    checks++; if (n_got !== 7) begin errors++; $display("FAIL abort fresh count got %0d want 7", n_got); end
    for (int k = 0; k < 7; k++) begin
      checks++; if (got[k] !== e[k]) begin errors++; $display("FAIL abort fresh C[%0d] got %0d want %0d", k, got[k], e[k]); end
    end
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL abort fresh done got %b want 1", dn); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_circular();
    test_linear();
    test_backpressure();
    test_random_load();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
